// File: rtl/slave_bus_monitor.sv
// slave_bus_monitor
// I2C slave front-end: brings raw SCL/SDA into the clk domain, detects
// START/STOP, tracks the bit position inside each 9-clock byte frame and
// shifts received data bits into rx_data for the slave main controller.
module slave_bus_monitor (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       SCL_in,
    input  logic       SDA_in,
    input  logic       rx_enable,
    output logic       SCL_sync,
    output logic       SDA_sync,
    output logic       start,
    output logic       stop,
    output logic       byte_received,
    output logic       ack_prep,
    output logic       ack_check,
    output logic       ack_done,
    output logic [7:0] rx_data,
    output logic [3:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BITS = 2'b01,
        ACK  = 2'b10
    } state_t;

    state_t state;

    // First synchronizer stage and one-cycle history of the synchronized lines.
    logic scl_p0;
    logic sda_p0;
    logic scl_prev;
    logic sda_prev;

    // Bus events derived only from registered values.
    logic scl_rise;
    logic scl_fall;
    logic start_cond;
    logic stop_cond;

    // Two-flop synchronizer plus a history flop per line; everything resets
    // to the idle-high bus level so reset release never looks like a START.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_p0   <= 1'b1;
            sda_p0   <= 1'b1;
            SCL_sync <= 1'b1;
            SDA_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_p0   <= SCL_in;
            sda_p0   <= SDA_in;
            SCL_sync <= scl_p0;
            SDA_sync <= sda_p0;
            scl_prev <= SCL_sync;
            sda_prev <= SDA_sync;
        end
    end

    assign scl_rise   =  SCL_sync & ~scl_prev;
    assign scl_fall   = ~SCL_sync &  scl_prev;
    assign start_cond =  scl_prev &  SCL_sync &  sda_prev & ~SDA_sync;
    assign stop_cond  =  scl_prev &  SCL_sync & ~sda_prev &  SDA_sync;

    // Frame tracker: START/STOP override any bit event in the same cycle;
    // every pulse output is registered and defaults low so it lasts one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            bit_count     <= 4'd0;
            rx_data       <= 8'h00;
            start         <= 1'b0;
            stop          <= 1'b0;
            byte_received <= 1'b0;
            ack_prep      <= 1'b0;
            ack_check     <= 1'b0;
            ack_done      <= 1'b0;
        end else begin
            start         <= 1'b0;
            stop          <= 1'b0;
            byte_received <= 1'b0;
            ack_prep      <= 1'b0;
            ack_check     <= 1'b0;
            ack_done      <= 1'b0;

            if (stop_cond) begin
                state     <= IDLE;
                bit_count <= 4'd0;
                stop      <= 1'b1;
            end else if (start_cond) begin
                state     <= BITS;
                bit_count <= 4'd0;
                start     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // Bus not owned by a transfer: SCL edges are ignored.
                    end
                    BITS: begin
                        if (scl_rise && (bit_count < 4'd8)) begin
                            bit_count <= bit_count + 4'd1;
                            if (rx_enable) begin
                                rx_data <= {rx_data[6:0], SDA_sync};
                            end
                            if (bit_count == 4'd7) begin
                                byte_received <= 1'b1;
                            end
                        end else if (scl_fall && (bit_count == 4'd8)) begin
                            state    <= ACK;
                            ack_prep <= 1'b1;
                        end
                    end
                    ACK: begin
                        // The ninth clock carries the acknowledge; never shifted in.
                        if (scl_rise) begin
                            bit_count <= 4'd9;
                            ack_check <= 1'b1;
                        end else if (scl_fall && (bit_count == 4'd9)) begin
                            state     <= BITS;
                            bit_count <= 4'd0;
                            ack_done  <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        bit_count <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slave_bus_monitor.sv
// Testbench for slave_bus_monitor: directed I2C bus sequences, a
// frame-level reference model checked every cycle, and literal checks.
module tb_slave_bus_monitor;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       SCL_in = 1'b1;
    logic       SDA_in = 1'b1;
    logic       rx_enable = 1'b1;
    logic       SCL_sync;
    logic       SDA_sync;
    logic       start;
    logic       stop;
    logic       byte_received;
    logic       ack_prep;
    logic       ack_check;
    logic       ack_done;
    logic [7:0] rx_data;
    logic [3:0] bit_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: bus as seen through the two-sample latency, frame position.
    bit [2:0] scl_seen;
    bit [2:0] sda_seen;
    bit       m_active;
    bit       m_in_ack;
    int       m_rises;
    bit [7:0] m_byte;
    bit       e_start, e_stop, e_br, e_prep, e_check, e_done;

    // Pulse counters and values captured at pulse cycles.
    int cnt_start = 0, cnt_stop = 0, cnt_br = 0, cnt_prep = 0, cnt_check = 0, cnt_done = 0;
    int cap_br_rx = -1, cap_br_bc = -1, cap_ck_bc = -1, cap_dn_bc = -1;

    slave_bus_monitor dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .SCL_in        (SCL_in),
        .SDA_in        (SDA_in),
        .rx_enable     (rx_enable),
        .SCL_sync      (SCL_sync),
        .SDA_sync      (SDA_sync),
        .start         (start),
        .stop          (stop),
        .byte_received (byte_received),
        .ack_prep      (ack_prep),
        .ack_check     (ack_check),
        .ack_done      (ack_done),
        .rx_data       (rx_data),
        .bit_count     (bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        scl_seen = 3'b111;
        sda_seen = 3'b111;
        m_active = 1'b0;
        m_in_ack = 1'b0;
        m_rises  = 0;
        m_byte   = 8'h00;
        e_start = 0; e_stop = 0; e_br = 0; e_prep = 0; e_check = 0; e_done = 0;
    endtask

    // One clk edge of the reference: classify the bus event visible at this
    // edge, apply the frame rules, then record the newly sampled raw lines.
    task automatic model_step();
        bit now_scl, was_scl, now_sda, was_sda;
        bit rise, fall, st, sp;
        now_scl = scl_seen[1]; was_scl = scl_seen[2];
        now_sda = sda_seen[1]; was_sda = sda_seen[2];
        rise = now_scl && !was_scl;
        fall = !now_scl && was_scl;
        st   = now_scl && was_scl && was_sda && !now_sda;
        sp   = now_scl && was_scl && !was_sda && now_sda;
        e_start = 0; e_stop = 0; e_br = 0; e_prep = 0; e_check = 0; e_done = 0;
        if (sp) begin
            m_active = 0; m_in_ack = 0; m_rises = 0; e_stop = 1;
        end else if (st) begin
            m_active = 1; m_in_ack = 0; m_rises = 0; e_start = 1;
        end else if (m_active) begin
            if (rise) begin
                if (m_in_ack) begin
                    m_rises = 9; e_check = 1;
                end else if (m_rises < 8) begin
                    m_rises++;
                    if (rx_enable) m_byte = {m_byte[6:0], now_sda};
                    if (m_rises == 8) e_br = 1;
                end
            end else if (fall) begin
                if (!m_in_ack && m_rises == 8) begin
                    m_in_ack = 1; e_prep = 1;
                end else if (m_in_ack && m_rises == 9) begin
                    m_in_ack = 0; m_rises = 0; e_done = 1;
                end
            end
        end
        scl_seen = {scl_seen[1:0], bit'(SCL_in)};
        sda_seen = {sda_seen[1:0], bit'(SDA_in)};
    endtask

    // Reference model advances on each clk edge and on reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) model_reset();
            else model_step();
        end
    end

    // Compare every output on the falling edge, count pulses, capture values.
    initial begin
        forever begin
            @(negedge clk);
            chk("SCL_sync", 32'(SCL_sync), 32'(scl_seen[1]));
            chk("SDA_sync", 32'(SDA_sync), 32'(sda_seen[1]));
            chk("start", 32'(start), 32'(e_start));
            chk("stop", 32'(stop), 32'(e_stop));
            chk("byte_received", 32'(byte_received), 32'(e_br));
            chk("ack_prep", 32'(ack_prep), 32'(e_prep));
            chk("ack_check", 32'(ack_check), 32'(e_check));
            chk("ack_done", 32'(ack_done), 32'(e_done));
            chk("rx_data", 32'(rx_data), 32'(m_byte));
            chk("bit_count", 32'(bit_count), 32'(m_rises));
            chk("pulse_exclusive",
                32'($countones({start, stop, byte_received, ack_prep, ack_check, ack_done}) <= 1), 32'd1);
            if (start === 1'b1) cnt_start++;
            if (stop === 1'b1) cnt_stop++;
            if (byte_received === 1'b1) begin
                cnt_br++; cap_br_rx = int'(rx_data); cap_br_bc = int'(bit_count);
            end
            if (ack_prep === 1'b1) cnt_prep++;
            if (ack_check === 1'b1) begin
                cnt_check++; cap_ck_bc = int'(bit_count);
            end
            if (ack_done === 1'b1) begin
                cnt_done++; cap_dn_bc = int'(bit_count);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        SCL_in = 1'b0; wait_clk(4);
        SDA_in = b;    wait_clk(4);
        SCL_in = 1'b1; wait_clk(8);
    endtask

    task automatic send_frame(input logic [7:0] data);
        cap_br_rx = -1; cap_br_bc = -1; cap_ck_bc = -1; cap_dn_bc = -1;
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        send_bit(1'b0);
        SCL_in = 1'b0; wait_clk(8);
    endtask

    task automatic do_start();
        SCL_in = 1'b0; wait_clk(4);
        SDA_in = 1'b1; wait_clk(4);
        SCL_in = 1'b1; wait_clk(4);
        SDA_in = 1'b0; wait_clk(8);
    endtask

    task automatic do_stop();
        SCL_in = 1'b0; wait_clk(4);
        SDA_in = 1'b0; wait_clk(4);
        SCL_in = 1'b1; wait_clk(4);
        SDA_in = 1'b1; wait_clk(8);
    endtask

    function automatic int pulse_total();
        return cnt_start + cnt_stop + cnt_br + cnt_prep + cnt_check + cnt_done;
    endfunction

    // Directed sequence with hand-computed expectations.
    initial begin
        int c0, c1, c2, c3, found, tot;
        wait_clk(4);
        chk("reset_SCL_sync", 32'(SCL_sync), 32'd1);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_bit_count", 32'(bit_count), 32'd0);
        n_rst = 1'b1;
        wait_clk(6);

        // START from idle: pulse on the third edge after the SDA drop.
        c0 = cnt_start;
        found = 0;
        SDA_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (start === 1'b1 && found == 0) found = i;
        end
        chk("start_latency", 32'(found), 32'd3);
        chk("start_count", 32'(cnt_start - c0), 32'd1);
        chk("start_bit_count", 32'(bit_count), 32'd0);
        wait_clk(1);

        // Byte 0xA5 with rx_enable high.
        c0 = cnt_br; c1 = cnt_prep; c2 = cnt_check; c3 = cnt_done;
        send_frame(8'hA5);
        chk("A5_rx_at_br", 32'(cap_br_rx), 32'hA5);
        chk("A5_bc_at_br", 32'(cap_br_bc), 32'd8);
        chk("A5_bc_at_check", 32'(cap_ck_bc), 32'd9);
        chk("A5_bc_at_done", 32'(cap_dn_bc), 32'd0);
        chk("A5_frame_pulses", 32'((cnt_br - c0) + (cnt_prep - c1) + (cnt_check - c2) + (cnt_done - c3)), 32'd4);

        // Byte 0x3C with rx_enable low: data holds, frame pulses still fire.
        rx_enable = 1'b0;
        c0 = cnt_br; c3 = cnt_done;
        send_frame(8'h3C);
        chk("noen_rx_held", 32'(rx_data), 32'hA5);
        chk("noen_rx_at_br", 32'(cap_br_rx), 32'hA5);
        chk("noen_br_count", 32'(cnt_br - c0), 32'd1);
        chk("noen_done_count", 32'(cnt_done - c3), 32'd1);
        rx_enable = 1'b1;

        // Repeated START after ack_done, then byte 0x5A.
        c0 = cnt_start;
        do_start();
        chk("rstart_count", 32'(cnt_start - c0), 32'd1);
        chk("rstart_bit_count", 32'(bit_count), 32'd0);
        send_frame(8'h5A);
        chk("rstart_rx_at_br", 32'(cap_br_rx), 32'h5A);

        // STOP mid-byte after four bits; later SCL activity is ignored.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        c0 = cnt_stop;
        do_stop();
        chk("stop_count", 32'(cnt_stop - c0), 32'd1);
        chk("stop_bit_count", 32'(bit_count), 32'd0);
        tot = pulse_total();
        c1 = int'(rx_data);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        SCL_in = 1'b0; wait_clk(8);
        chk("idle_no_pulses", 32'(pulse_total() - tot), 32'd0);
        chk("idle_bit_count", 32'(bit_count), 32'd0);
        chk("idle_rx_held", 32'(rx_data), 32'(c1));

        // Reset asserted after five bits of a frame.
        do_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        SCL_in = 1'b0; SDA_in = 1'b0; wait_clk(4);
        tot = pulse_total();
        n_rst = 1'b0;
        wait_clk(3);
        chk("midrst_SCL_sync", 32'(SCL_sync), 32'd1);
        chk("midrst_SDA_sync", 32'(SDA_sync), 32'd1);
        chk("midrst_rx_data", 32'(rx_data), 32'h00);
        chk("midrst_bit_count", 32'(bit_count), 32'd0);
        n_rst = 1'b1;
        wait_clk(6);
        chk("midrst_no_pulses", 32'(pulse_total() - tot), 32'd0);
        do_start();
        send_frame(8'h81);
        chk("after_rst_rx_at_br", 32'(cap_br_rx), 32'h81);
        chk("after_rst_bc_at_done", 32'(cap_dn_bc), 32'd0);
        do_stop();
        wait_clk(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
